// File: rtl/icache_if.sv
// Refill bus between the instruction cache and the memory controller.
//   mem_req   : cache -> mem, level-held while a line refill is in progress
//   mem_addr  : cache -> mem, byte address of the word currently wanted
//   mem_valid : mem -> cache, one-cycle pulse, mem_data holds the word at mem_addr
//   mem_data  : mem -> cache, refill data word
interface icache_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_valid, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_valid, output mem_data);
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 4-word lines.
//   clk, rst     : clock, synchronous active-high reset
//   rdy          : global enable, all state holds while low
//   pc_in        : fetch address (bits [1:0] ignored)
//   stall_ID     : decoder stall, holds a presented instruction
//   jp_wrong     : mispredict flush, drops the current output
//   ins_flag/ins : registered instruction valid / word for the current PC
//   mem          : refill bus (icache_if.master)
module icache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_in,
  input  logic        stall_ID,
  input  logic        jp_wrong,
  output logic        ins_flag,
  output logic [31:0] ins,
  icache_if.master    mem
);

  localparam int unsigned LINES     = 1 << INDEX_BITS;
  localparam int unsigned LINE_BITS = 28;
  localparam int unsigned TAG_BITS  = LINE_BITS - INDEX_BITS;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES][4];
  logic [1:0]            cnt_q, cnt_d;
  logic [LINE_BITS-1:0]  line_q, line_d;
  logic                  ins_flag_d;
  logic [31:0]           ins_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  fill_start, word_we, fill_done;

  // Fetch address split and the line being refilled.
  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  unused_pc;

  assign offset     = pc_in[3:2];
  assign index      = pc_in[INDEX_BITS+3:4];
  assign tag        = pc_in[31:INDEX_BITS+4];
  assign fill_index = line_q[INDEX_BITS-1:0];
  assign fill_tag   = line_q[LINE_BITS-1:INDEX_BITS];
  assign hit        = valid_q[index] && (tag_q[index] == tag);
  assign unused_pc  = ^pc_in[1:0];

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  // Next-state and output logic; everything holds unless rdy is high.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    ins_flag_d = ins_flag;
    ins_d      = ins;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_start = 1'b0;
    word_we    = 1'b0;
    fill_done  = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (jp_wrong) begin
            ins_flag_d = 1'b0;
          end else if (stall_ID && ins_flag) begin
            // decoder has not taken the presented word yet: keep it
          end else if (hit) begin
            ins_flag_d = 1'b1;
            ins_d      = data_q[index][offset];
          end else begin
            ins_flag_d = 1'b0;
            line_d     = {tag, index};
            cnt_d      = 2'd0;
            mem_req_d  = 1'b1;
            mem_addr_d = {tag, index, 4'b0000};
            fill_start = 1'b1;
            state_d    = REFILL;
          end
        end
        REFILL: begin
          ins_flag_d = 1'b0;
          if (mem.mem_valid) begin
            word_we = 1'b1;
            cnt_d   = 2'(cnt_q + 2'd1);
            if (cnt_q == 2'd3) begin
              fill_done  = 1'b1;
              mem_req_d  = 1'b0;
              mem_addr_d = 32'd0;
              state_d    = IDLE;
            end else begin
              mem_addr_d = {line_q, 2'(cnt_q + 2'd1), 2'b00};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= 2'd0;
      line_q     <= '0;
      ins_flag   <= 1'b0;
      ins        <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      ins_flag   <= ins_flag_d;
      ins        <= ins_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      // a line under refill must never hit until all four words are in
      if (fill_start) valid_q[index]      <= 1'b0;
      if (fill_done)  valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk) begin
    if (!rst && word_we)   data_q[fill_index][cnt_q] <= mem.mem_data;
    if (!rst && fill_done) tag_q[fill_index]         <= fill_tag;
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_in;
  logic        stall_ID;
  logic        jp_wrong;
  logic        ins_flag;
  logic [31:0] ins;

  icache_if mif ();

  icache #(.INDEX_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .pc_in    (pc_in),
    .stall_ID (stall_ID),
    .jp_wrong (jp_wrong),
    .ins_flag (ins_flag),
    .ins      (ins),
    .mem      (mif)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          refills  = 0;
  int          exp_refills = 0;
  logic [31:0] exp_ins  [$];
  logic [31:0] exp_addr [$];
  logic        prev_req = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory image: first line hand-filled, everything else tagged by address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h11;
      32'h4: return 32'h22;
      32'h8: return 32'h33;
      32'hC: return 32'h44;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Memory responder: one word per pulse, a cycle after each request.
  initial begin
    mif.mem_valid = 1'b0;
    mif.mem_data  = 32'd0;
    forever begin
      @(posedge clk);
      #3;
      if (mif.mem_valid) begin
        mif.mem_valid = 1'b0;
      end else if (mif.mem_req && rdy && !rst) begin
        mif.mem_valid = 1'b1;
        mif.mem_data  = mem_word(mif.mem_addr);
      end
    end
  end

  // Monitor: instruction outputs, refill addresses and refill starts.
  always @(negedge clk) begin
    if (ins_flag === 1'b1) begin
      if (exp_ins.size() == 0) chk("unexpected_ins", ins, 32'hxxxx_xxxx);
      else chk("ins", ins, exp_ins.pop_front());
    end
    if (mif.mem_valid === 1'b1) begin
      if (exp_addr.size() == 0) chk("unexpected_refill_word", mif.mem_addr, 32'hxxxx_xxxx);
      else chk("mem_addr", mif.mem_addr, exp_addr.pop_front());
    end
    if (mif.mem_req && !prev_req) refills++;
    prev_req = mif.mem_req;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mif.mem_req === 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("refill_timeout", 32'(mif.mem_req), 32'd0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp);
    jp_wrong = 1'b0;
    stall_ID = 1'b0;
    pc_in    = pc;
    exp_ins.push_back(exp);
    step();
  endtask

  task automatic quiet();
    jp_wrong = 1'b1;
    stall_ID = 1'b0;
    step();
  endtask

  task automatic miss(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(4 * i));
    exp_refills++;
    jp_wrong = 1'b0;
    stall_ID = 1'b0;
    pc_in    = base;
    step();
    chk("miss_req", 32'(mif.mem_req), 32'd1);
    chk("miss_first_addr", mif.mem_addr, base);
    jp_wrong = 1'b1;
    wait_idle();
    chk("ins_flag_after_fill", 32'(ins_flag), 32'd0);
    chk("refill_count", 32'(refills), 32'(exp_refills));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; pc_in = 32'd0; stall_ID = 1'b0; jp_wrong = 1'b0;
    step();
    step();
    chk("rst_ins_flag", 32'(ins_flag), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_mem_addr", mif.mem_addr, 32'd0);
    rst = 1'b0;

    // cold miss then sequential hits over the line
    miss(32'h0);
    fetch(32'h0, 32'h11);
    fetch(32'h4, 32'h22);
    fetch(32'h8, 32'h33);
    fetch(32'hC, 32'h44);
    quiet();
    chk("hits_no_refill", 32'(refills), 32'(exp_refills));

    // conflict eviction at index 0
    miss(32'h400);
    fetch(32'h400, 32'hC0DE0400);
    quiet();
    miss(32'h0);
    fetch(32'h0, 32'h11);
    quiet();

    // flush in the middle of a refill
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'h40 + 32'(4 * i));
    exp_refills++;
    jp_wrong = 1'b0;
    pc_in    = 32'h40;
    step();
    step();
    step();
    jp_wrong = 1'b1;
    step();
    jp_wrong = 1'b0;
    wait_idle();
    chk("flush_ins_flag", 32'(ins_flag), 32'd0);
    fetch(32'h40, 32'hC0DE0040);
    quiet();
    chk("flush_refill_count", 32'(refills), 32'(exp_refills));

    // stall holds the presented word
    fetch(32'h8, 32'h33);
    stall_ID = 1'b1;
    pc_in    = 32'hC;
    for (int i = 0; i < 3; i++) begin
      exp_ins.push_back(32'h33);
      step();
    end
    stall_ID = 1'b0;
    exp_ins.push_back(32'h44);
    step();
    quiet();

    // rdy low freezes a refill
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'h80 + 32'(4 * i));
    exp_refills++;
    jp_wrong = 1'b0;
    pc_in    = 32'h80;
    step();
    jp_wrong = 1'b1;
    step();
    rdy = 1'b0;
    step();
    chk("rdy_low_addr_0", mif.mem_addr, 32'h84);
    chk("rdy_low_cnt_0", 32'(dut.cnt_q), 32'd1);
    step();
    chk("rdy_low_addr_1", mif.mem_addr, 32'h84);
    chk("rdy_low_cnt_1", 32'(dut.cnt_q), 32'd1);
    chk("rdy_low_req", 32'(mif.mem_req), 32'd1);
    rdy = 1'b1;
    wait_idle();
    fetch(32'h88, 32'hC0DE0088);
    quiet();

    // reset after the second refill word abandons the line
    exp_addr.push_back(32'hC0);
    exp_addr.push_back(32'hC4);
    exp_refills++;
    jp_wrong = 1'b0;
    pc_in    = 32'hC0;
    step();
    jp_wrong = 1'b1;
    for (int n = 0; n < 20 && mif.mem_addr !== 32'hC8; n++) step();
    chk("two_words_in", mif.mem_addr, 32'hC8);
    rst = 1'b1;
    step();
    chk("mid_rst_req", 32'(mif.mem_req), 32'd0);
    chk("mid_rst_addr", mif.mem_addr, 32'd0);
    chk("mid_rst_ins_flag", 32'(ins_flag), 32'd0);
    rst = 1'b0;
    step();
    miss(32'hC0);
    fetch(32'hC0, 32'hC0DE00C0);
    quiet();
    step();

    chk("ins_queue_drained", 32'(exp_ins.size()), 32'd0);
    chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    chk("final_refill_count", 32'(refills), 32'(exp_refills));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and the memory controller. Each enabled cycle it looks up the fetch address `pc_in` and returns one registered instruction word. On a miss it refills a 4-word line from memory, then serves the request on a later lookup. It honours fetch-side stall and branch-flush signals, so `ins_flag`/`ins` always correspond to the fetch stage's current PC.

## Interface
- `INDEX_BITS`, default 6, is the log2 of the line count; the default gives 64 lines × 16 B = 1 KiB.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; when 0, no state changes.
- `pc_in`  in  32  fetch address from IF; bits [1:0] are ignored.
- `stall_ID`  in  1  decoder cannot accept the presented instruction.
- `jp_wrong`  in  1  ROB mispredict flush.
- `ins_flag`  out  1  registered: `ins` is valid for the fetch stage's current PC.
- `ins`  out  32  registered instruction word.
- `mem_req`  out  1  registered refill request, level-held for the whole refill.
- `mem_addr`  out  32  word address being requested.
- `mem_valid`  in  1  one-cycle pulse: `mem_data` holds the word at `mem_addr`.
- `mem_data`  in  32  refill data.

## Operation
- Address split:
  - offset = `pc_in[3:2]`
  - index = `pc_in[INDEX_BITS+3:4]`
  - tag = `pc_in[31:INDEX_BITS+4]`
- Storage per line: valid bit, tag, and 4×32-bit data words.
- State machine: IDLE and REFILL, plus a 2-bit word counter `cnt` and a latched line address `line_addr` holding tag and index.
- Priority each edge is `rst` > `!rdy` > `jp_wrong` > `stall_ID` hold > normal operation.
- `rst`:
  - all valid bits clear
  - `ins_flag`=0, `ins`=0
  - `mem_req`=0, `mem_addr`=0
  - `cnt`=0, state IDLE
  - A reset during a refill abandons it and writes no line.
- `rdy`=0: all registers hold. The memory side must not pulse `mem_valid` while `rdy`=0.
- `jp_wrong`=1:
  - `ins_flag`<=0, and no lookup occurs that cycle.
  - In IDLE no refill starts.
  - In REFILL the refill continues unchanged; the line is still written.
- `stall_ID`=1 with `ins_flag`=1: `ins_flag` and `ins` hold and no lookup occurs. A REFILL in progress continues.
- IDLE lookup (when not held or flushed):
  - Hit (valid and tag equal): `ins_flag`<=1, `ins`<=data[index][offset].
  - Miss:
    - `ins_flag`<=0, latch `line_addr`
    - `cnt`<=0, `mem_req`<=1, `mem_addr`<={tag,index,2'b00,2'b00}
    - go to REFILL
- REFILL:
  - `ins_flag`=0 throughout.
  - On `mem_valid`, data[index][`cnt`]<=`mem_data`, `cnt`<=`cnt`+1, and `mem_addr`<=line base + 4·(`cnt`+1).
  - On the 4th word (`cnt`=3 and `mem_valid`):
    - set valid, write tag
    - `mem_req`<=0, `mem_addr`<=0
    - go to IDLE
  - The line's valid bit is cleared when the refill starts, so a partly written line never hits.
- A refilled line replaces any previous line at that index (eviction). The cache has no write path and needs no coherence.

## Timing
- Hit latency is 1 cycle: `pc_in` sampled at edge k gives `ins_flag`/`ins` valid after edge k.
- Back-to-back hits sustain 1 instruction per cycle.
- Miss timing:
  - `mem_req` and the first `mem_addr` are asserted after the sampling edge.
  - The line is complete at the edge that captures the 4th `mem_valid`; `ins_flag` is still 0 after that edge.
  - The next IDLE lookup, one edge later, hits.
  - Total miss penalty = memory latency for 4 words + 2 cycles.
- `mem_valid` in IDLE is ignored.
- `mem_addr` is stable while `mem_req`=1 and no `mem_valid` arrives.
- After a flush, `ins_flag` is 0 for at least one cycle. The next lookup uses `pc_in`, which then equals the flush target.

## Test plan
- Cold miss:
  - Stimulus: after reset, `pc_in`=0x0000_0000; memory returns 0x11,0x22,0x33,0x44 one cycle after each request.
  - Required: `mem_addr` steps through 0x0, 0x4, 0x8, 0xC; `mem_req` drops after the 4th word; next lookup gives `ins_flag`=1, `ins`=0x11.
- Sequential hits:
  - Stimulus: `pc_in` 0x4, 0x8, 0xC on consecutive cycles.
  - Required: `ins` = 0x22, 0x33, 0x44 on consecutive cycles; `mem_req` stays 0.
- Conflict eviction (default `INDEX_BITS`):
  - Stimulus: fetch 0x400 (same index as 0x0, different tag), then fetch 0x0.
  - Required: two full refills; the second returns 0x11 again.
- Flush during refill:
  - Stimulus: miss on 0x40, then `jp_wrong`=1 for one cycle mid-refill.
  - Required: refill completes and `ins_flag` stays 0; a later lookup of 0x40 hits with no new `mem_req`.
- Stall hold:
  - Stimulus: hit on 0x8, then `stall_ID`=1 for 3 cycles while `pc_in` changes to 0xC.
  - Required: `ins`=0x33 and `ins_flag`=1 held for all 3 cycles; 0x44 appears one cycle after the stall releases.
- `rdy` low and reset mid-refill:
  - Stimulus: `rdy`=0 for 2 cycles during a refill.
  - Required: `cnt` and `mem_addr` are frozen.
  - Stimulus: `rst` asserted after the 2nd refill word.
  - Required: `mem_req`=0, and a later fetch of that line misses.
